apb_master_arbiter: RTL and testbench

- Shares one APB master port (the `apb_if` signal set: paddr, pwdata, prdata, psel, penable, pwrite, uart_int) between NUM_REQ internal requesters, e.g. the UART driver engine, a DMA engine and a config loader.
- Arbitrates round-robin, with an optional interrupt-priority override driven by uart_int.
- Sequences each transfer through the APB SETUP and ACCESS phases.
- The bus has no pready/pslverr, so every transfer is exactly one SETUP cycle plus one ACCESS cycle.

---
 rtl/apb_master_arbiter.sv | 172 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters. Arbitration is round-robin
// with an optional uart_int priority override, and every transfer is one SETUP plus one ACCESS cycle.
module apb_master_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int IRQ_REQ     = 0,
    parameter int IRQ_PRIO_EN = 1
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      uart_int,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   winner_q, winner_d;

    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic               start;

    // Round-robin search starts just after the last winner; the IRQ requester overrides it.
    always_comb begin : arb_comb
        int cand;
        arb_valid = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!arb_valid && req[IDX_W'(cand)]) begin
                arb_valid = 1'b1;
                arb_idx   = IDX_W'(cand);
            end
        end
        if ((IRQ_PRIO_EN != 0) && uart_int && req[IDX_W'(IRQ_REQ)]) begin
            arb_valid = 1'b1;
            arb_idx   = IDX_W'(IRQ_REQ);
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        done_d    = '0;
        rdata_d   = rdata_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        busy_d    = 1'b0;
        last_d    = last_q;
        winner_d  = winner_q;
        start     = 1'b0;

        case (state_q)
            IDLE: begin
                start = arb_valid;
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                busy_d    = 1'b1;
            end
            ACCESS: begin
                done_d[winner_q] = 1'b1;
                if (!pwrite_q) begin
                    rdata_d = prdata;
                end
                if (arb_valid) begin
                    start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new grant latches the winner's fields; the bus then ignores the requester until done.
        if (start) begin
            state_d        = SETUP;
            psel_d         = 1'b1;
            penable_d      = 1'b0;
            busy_d         = 1'b1;
            gnt_d[arb_idx] = 1'b1;
            paddr_d        = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
            pwdata_d       = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
            pwrite_d       = req_write[arb_idx];
            last_d         = arb_idx;
            winner_d       = arb_idx;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            winner_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            busy_q    <= busy_d;
            last_q    <= last_d;
            winner_q  <= winner_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pwrite  = pwrite_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level round-robin model.
module tb_apb_master_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            pclk = 1'b0;
    logic            presetn;
    logic [N-1:0]    req, req_write, gnt, done;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rdata, pwdata, prdata;
    logic [AW-1:0]   paddr;
    logic            pwrite, psel, penable, uart_int, busy;

    int tests_run    = 0;
    int tests_failed = 0;

    apb_master_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .IRQ_REQ(3), .IRQ_PRIO_EN(1)
    ) dut (
        .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .prdata(prdata), .uart_int(uart_int),
        .busy(busy)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic mid();
        @(negedge pclk);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_write[IW'(i)]     = w;
    endtask

    task automatic do_reset();
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        prdata = '0; uart_int = 1'b0;
        presetn = 1'b0;
        cyc();
        cyc();
        presetn = 1'b1;
    endtask

    // Spec-level arbitration rule: IRQ requester first, else first set bit after the last winner.
    function automatic int pick(input logic [N-1:0] r, input int lst, input logic irq);
        logic [N-1:0] t;
        if (irq && r[3]) return 3;
        for (int k = 1; k <= N; k++) begin
            t = r >> ((lst + k) % N);
            if (t[0]) return (lst + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        req = 4'hF; req_write = 4'hF; uart_int = 1'b1; prdata = 32'hFFFF_FFFF;
        presetn = 1'b0;
        cyc();
        mid();
        tests_run++; if (gnt !== 4'b0) begin tests_failed++; $display("[TB] FAIL rst_gnt: got %b want 0000", gnt); end
        tests_run++; if (done !== 4'b0) begin tests_failed++; $display("[TB] FAIL rst_done: got %b want 0000", done); end
        tests_run++; if ({psel, penable, pwrite, busy} !== 4'b0) begin tests_failed++; $display("[TB] FAIL rst_ctrl: got %b want 0000", {psel, penable, pwrite, busy}); end
        tests_run++; if (paddr !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_paddr: got %h want 0", paddr); end
        tests_run++; if (pwdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_pwdata: got %h want 0", pwdata); end
        tests_run++; if (rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_rdata: got %h want 0", rdata); end
    endtask

    task automatic test_write_single();
        do_reset();
        set_req(0, 32'h10, 32'hA5, 1'b1);
        req = 4'b0001;
        mid();
        tests_run++; if (psel !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_c0_psel: got %b want 0", psel); end
        cyc(); mid();
        tests_run++; if ({psel, penable} !== 2'b10) begin tests_failed++; $display("[TB] FAIL wr_c1_phase: got %b want 10", {psel, penable}); end
        tests_run++; if (paddr !== 32'h10) begin tests_failed++; $display("[TB] FAIL wr_c1_paddr: got %h want 10", paddr); end
        tests_run++; if (pwdata !== 32'hA5) begin tests_failed++; $display("[TB] FAIL wr_c1_pwdata: got %h want a5", pwdata); end
        tests_run++; if (pwrite !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_c1_pwrite: got %b want 1", pwrite); end
        tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("[TB] FAIL wr_c1_gnt: got %b want 0001", gnt); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_c1_busy: got %b want 1", busy); end
        cyc(); req = 4'b0; mid();
        tests_run++; if ({psel, penable} !== 2'b11) begin tests_failed++; $display("[TB] FAIL wr_c2_phase: got %b want 11", {psel, penable}); end
        tests_run++; if ({gnt, done} !== 8'b0) begin tests_failed++; $display("[TB] FAIL wr_c2_pulses: got %b want 00000000", {gnt, done}); end
        cyc(); mid();
        tests_run++; if (done !== 4'b0001) begin tests_failed++; $display("[TB] FAIL wr_c3_done: got %b want 0001", done); end
        tests_run++; if ({psel, busy} !== 2'b00) begin tests_failed++; $display("[TB] FAIL wr_c3_idle: got %b want 00", {psel, busy}); end
        tests_run++; if (paddr !== 32'h10) begin tests_failed++; $display("[TB] FAIL wr_c3_paddr_hold: got %h want 10", paddr); end
        cyc(); mid();
        tests_run++; if (done !== 4'b0) begin tests_failed++; $display("[TB] FAIL wr_c4_done: got %b want 0000", done); end
    endtask

    task automatic test_read();
        do_reset();
        set_req(2, 32'h04, 32'h0, 1'b0);
        req = 4'b0100;
        cyc(); mid();
        tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("[TB] FAIL rd_gnt: got %b want 0100", gnt); end
        tests_run++; if ({pwrite, paddr} !== {1'b0, 32'h04}) begin tests_failed++; $display("[TB] FAIL rd_fields: got %b/%h want 0/4", pwrite, paddr); end
        cyc(); req = 4'b0; prdata = 32'h1234_5678; mid();
        tests_run++; if (penable !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_penable: got %b want 1", penable); end
        cyc(); prdata = 32'hFFFF_0000; mid();
        tests_run++; if (done !== 4'b0100) begin tests_failed++; $display("[TB] FAIL rd_done: got %b want 0100", done); end
        tests_run++; if (rdata !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL rd_rdata: got %h want 12345678", rdata); end
        cyc(); mid();
        tests_run++; if (rdata !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL rd_rdata_hold: got %h want 12345678", rdata); end
    endtask

    task automatic test_back_to_back();
        int order[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] eg, ed;
        logic [AW-1:0] ea;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'h100 + 32'(i * 4), 32'hD0 + 32'(i), 1'b1);
        req = 4'hF;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 10) req = 4'b0;
            mid();
            tests_run++; if (psel !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_psel c%0d: got %b want 1", c, psel); end
            tests_run++; if (penable !== ((c % 2) == 0)) begin tests_failed++; $display("[TB] FAIL b2b_penable c%0d: got %b want %0d", c, penable, (c % 2) == 0); end
            eg = ((c % 2) == 1) ? (4'b0001 << order[(c - 1) / 2]) : 4'b0000;
            tests_run++; if (gnt !== eg) begin tests_failed++; $display("[TB] FAIL b2b_gnt c%0d: got %b want %b", c, gnt, eg); end
            ed = ((c % 2) == 1 && c >= 3) ? (4'b0001 << order[(c - 3) / 2]) : 4'b0000;
            tests_run++; if (done !== ed) begin tests_failed++; $display("[TB] FAIL b2b_done c%0d: got %b want %b", c, done, ed); end
            if ((c % 2) == 1) begin
                ea = 32'h100 + 32'(order[(c - 1) / 2] * 4);
                tests_run++; if (paddr !== ea) begin tests_failed++; $display("[TB] FAIL b2b_paddr c%0d: got %h want %h", c, paddr, ea); end
            end
        end
        cyc(); mid();
        tests_run++; if ({psel, done} !== {1'b0, 4'b0001}) begin tests_failed++; $display("[TB] FAIL b2b_end: got %b want 00001", {psel, done}); end
    endtask

    task automatic test_irq_override();
        logic [N-1:0] first, second;
        for (int m = 0; m < 2; m++) begin
            first  = (m == 0) ? 4'b1000 : 4'b0010;
            second = (m == 0) ? 4'b0010 : 4'b1000;
            do_reset();
            set_req(0, 32'h20, 32'h1, 1'b1);
            set_req(1, 32'h24, 32'h2, 1'b1);
            set_req(3, 32'h2C, 32'h3, 1'b1);
            req = 4'b0001;
            cyc(); mid();
            tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("[TB] FAIL irq%0d_setup_gnt: got %b want 0001", m, gnt); end
            cyc(); req = 4'b1010; uart_int = (m == 0); mid();
            cyc(); mid();
            tests_run++; if (gnt !== first) begin tests_failed++; $display("[TB] FAIL irq%0d_first_gnt: got %b want %b", m, gnt, first); end
            tests_run++; if (done !== 4'b0001) begin tests_failed++; $display("[TB] FAIL irq%0d_first_done: got %b want 0001", m, done); end
            cyc(); req = 4'b1010 & ~first; mid();
            cyc(); mid();
            tests_run++; if (gnt !== second) begin tests_failed++; $display("[TB] FAIL irq%0d_second_gnt: got %b want %b", m, gnt, second); end
            tests_run++; if (done !== first) begin tests_failed++; $display("[TB] FAIL irq%0d_second_done: got %b want %b", m, done, first); end
            cyc(); req = 4'b0; uart_int = 1'b0; mid();
            cyc(); mid();
            tests_run++; if ({psel, done} !== {1'b0, second}) begin tests_failed++; $display("[TB] FAIL irq%0d_end: got %b want 0%b", m, {psel, done}, second); end
        end
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        set_req(1, 32'h30, 32'h0, 1'b0);
        req = 4'b0010;
        cyc(); mid();
        tests_run++; if (gnt !== 4'b0010) begin tests_failed++; $display("[TB] FAIL rmid_gnt: got %b want 0010", gnt); end
        cyc(); prdata = 32'hDEAD_BEEF; mid();
        cyc(); prdata = 32'h0; mid();
        tests_run++; if ({gnt, done} !== 8'b0010_0010) begin tests_failed++; $display("[TB] FAIL rmid_b2b: got %b want 00100010", {gnt, done}); end
        tests_run++; if (rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL rmid_rdata1: got %h want deadbeef", rdata); end
        cyc(); req = 4'b0; prdata = 32'hCAFE_F00D; mid();
        tests_run++; if ({psel, penable} !== 2'b11) begin tests_failed++; $display("[TB] FAIL rmid_access: got %b want 11", {psel, penable}); end
        #1 presetn = 1'b0;
        #1;
        tests_run++; if ({psel, penable, busy} !== 3'b000) begin tests_failed++; $display("[TB] FAIL rmid_async: got %b want 000", {psel, penable, busy}); end
        tests_run++; if (rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL rmid_rdata_clr: got %h want 0", rdata); end
        for (int c = 0; c < 2; c++) begin
            @(posedge pclk);
            mid();
            tests_run++; if (done !== 4'b0) begin tests_failed++; $display("[TB] FAIL rmid_no_done c%0d: got %b want 0000", c, done); end
        end
        cyc();
        set_req(0, 32'h40, 32'h5, 1'b1);
        set_req(1, 32'h44, 32'h6, 1'b1);
        req = 4'b0011;
        presetn = 1'b1;
        mid();
        tests_run++; if ({psel, rdata} !== {1'b0, 32'h0}) begin tests_failed++; $display("[TB] FAIL rmid_idle: got %b/%h want 0/0", psel, rdata); end
        cyc(); mid();
        tests_run++; if ({gnt, paddr} !== {4'b0001, 32'h40}) begin tests_failed++; $display("[TB] FAIL rmid_regrant: got %b/%h want 0001/40", gnt, paddr); end
        cyc(); req = 4'b0010; mid();
        cyc(); req = 4'b0; mid();
        tests_run++; if ({gnt, done} !== 8'b0010_0001) begin tests_failed++; $display("[TB] FAIL rmid_second: got %b want 00100001", {gnt, done}); end
        cyc(); cyc();
    endtask

    task automatic test_simultaneous_after_reset();
        do_reset();
        set_req(0, 32'h50, 32'h7, 1'b1);
        set_req(1, 32'h54, 32'h8, 1'b0);
        req = 4'b0011;
        cyc(); mid();
        tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("[TB] FAIL sim_c1_gnt: got %b want 0001", gnt); end
        cyc(); req = 4'b0010; mid();
        cyc(); mid();
        tests_run++; if (done !== 4'b0001) begin tests_failed++; $display("[TB] FAIL sim_c3_done: got %b want 0001", done); end
        tests_run++; if (gnt !== 4'b0010) begin tests_failed++; $display("[TB] FAIL sim_c3_gnt: got %b want 0010", gnt); end
        tests_run++; if ({psel, penable} !== 2'b10) begin tests_failed++; $display("[TB] FAIL sim_c3_phase: got %b want 10", {psel, penable}); end
        cyc(); req = 4'b0; prdata = 32'h0BAD_F00D; mid();
        cyc(); mid();
        tests_run++; if (done !== 4'b0010) begin tests_failed++; $display("[TB] FAIL sim_c5_done: got %b want 0010", done); end
        tests_run++; if (rdata !== 32'h0BAD_F00D) begin tests_failed++; $display("[TB] FAIL sim_c5_rdata: got %h want 0badf00d", rdata); end
        tests_run++; if (psel !== 1'b0) begin tests_failed++; $display("[TB] FAIL sim_c5_psel: got %b want 0", psel); end
    endtask

    // Model tracks the transfer granted this cycle, the one in its access cycle and the one completing.
    task automatic test_random();
        bit s_v, a_v, d_v, s_w, a_w, arb;
        int s_i, a_i, d_i, last, w;
        logic [N-1:0] e_gnt, e_done, t;
        logic [AW-1:0] e_paddr;
        logic [DW-1:0] e_pwdata, e_rdata;
        logic e_pwrite;
        do_reset();
        s_v = 0; a_v = 0; d_v = 0; s_w = 0; a_w = 0;
        s_i = 0; a_i = 0; d_i = 0; last = N - 1;
        e_paddr = '0; e_pwdata = '0; e_rdata = '0; e_pwrite = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (a_v) req[IW'(a_i)] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req[IW'(i)] && ($urandom_range(0, 99) < 40)) begin
                    set_req(i, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
                    req[IW'(i)] = 1'b1;
                end
            end
            uart_int = ($urandom_range(0, 3) == 0);
            prdata   = $urandom();
            mid();
            e_gnt  = s_v ? (4'b0001 << s_i) : 4'b0000;
            e_done = d_v ? (4'b0001 << d_i) : 4'b0000;
            tests_run++; if (gnt !== e_gnt) begin tests_failed++; $display("[TB] FAIL rnd_gnt c%0d: got %b want %b", c, gnt, e_gnt); end
            tests_run++; if (done !== e_done) begin tests_failed++; $display("[TB] FAIL rnd_done c%0d: got %b want %b", c, done, e_done); end
            tests_run++; if ({psel, penable, busy} !== {s_v | a_v, a_v, s_v | a_v}) begin tests_failed++; $display("[TB] FAIL rnd_ctrl c%0d: got %b want %b", c, {psel, penable, busy}, {s_v | a_v, a_v, s_v | a_v}); end
            tests_run++; if ({pwrite, paddr, pwdata} !== {e_pwrite, e_paddr, e_pwdata}) begin tests_failed++; $display("[TB] FAIL rnd_bus c%0d: got %b/%h/%h want %b/%h/%h", c, pwrite, paddr, pwdata, e_pwrite, e_paddr, e_pwdata); end
            tests_run++; if (rdata !== e_rdata) begin tests_failed++; $display("[TB] FAIL rnd_rdata c%0d: got %h want %h", c, rdata, e_rdata); end
            arb = !s_v;
            if (a_v && !a_w) e_rdata = prdata;
            d_v = a_v; d_i = a_i;
            a_v = s_v; a_i = s_i; a_w = s_w;
            s_v = 0;
            if (arb) begin
                w = pick(req, last, uart_int);
                if (w >= 0) begin
                    s_v = 1; s_i = w; last = w;
                    t = req_write >> w;
                    s_w = t[0];
                    e_pwrite = t[0];
                    e_paddr  = req_addr[w*AW +: AW];
                    e_pwdata = req_wdata[w*DW +: DW];
                end
            end
            cyc();
        end
        req = '0; uart_int = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    initial begin
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        prdata = '0; uart_int = 1'b0; presetn = 1'b0;
        test_reset();
        test_write_single();
        test_read();
        test_back_to_back();
        test_irq_override();
        test_reset_mid_transfer();
        test_simultaneous_after_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
